mux8_rr_sched: RTL
==================

# mux8_rr_sched

Round-robin scheduler that shares the 8:1 single-bit mux datapath between eight requesters. It arbitrates among `req[7:0]` and drives the mux's 3-bit select. It holds each grant for a programmable number of accepted beats, or until the owner withdraws its request. A valid/ready handshake toward the downstream consumer qualifies each beat taken through the mux.

## Interface
Parameters:
- `DWELL_W`, default 4: width of the dwell (beats-per-grant) setting.

Ports:
- `clk`  input  1  single clock; all state updates on the rising edge.
- `rst_n`  input  1  reset, asynchronous, active-low.
- `req`  input  8  request lines; bit i requests mux input i.
- `dwell`  input  DWELL_W  beats allowed per grant; 0 means 1. Sampled only at grant time.
- `ready`  input  1  downstream accepts the current mux output this cycle.
- `sel`  output  3  registered mux select; connects to the mux select.
- `gnt`  output  8  registered one-hot grant; all zero when idle.
- `valid`  output  1  combinational; mux output is valid this cycle.
- `busy`  output  1  registered; high in the GRANT state.

## Operation
- Two-state FSM: IDLE and GRANT. Internal registers:
  - `ptr[2:0]`: next-highest-priority index.
  - `cnt[DWELL_W-1:0]`: beats remaining.
- IDLE, with `req` != 0:
  - Select the first index i with `req[i]`=1, searching circularly from `ptr`: ptr, ptr+1, …, ptr+7, all mod 8.
  - Next edge: `sel`<=i, `gnt`<=1<<i, `cnt`<=(`dwell`==0 ? 1 : `dwell`), state<=GRANT.
- IDLE, with `req`==0: state, `sel`, `ptr` and `cnt` are held; `gnt`<=0.
- GRANT:
  - `valid` = `req[sel]`.
  - A beat occurs when `valid` && `ready`.
  - On a beat with `cnt`==1: release.
  - On a beat with `cnt`>1: `cnt` decrements.
  - If `req[sel]`==0: release immediately; no beat occurs that cycle.
  - Without a beat, `ready` alone changes nothing (backpressure holds the grant indefinitely).
- Release, at the next edge:
  - state<=IDLE, `gnt`<=0, `ptr`<=`sel`+1 mod 8 (7 wraps to 0).
  - `sel` keeps its last value.
- Fairness: a requester that was just released has lowest priority at the next arbitration. Any continuously requesting input is granted within 7 intervening grants.
- Requests from other inputs during GRANT do not preempt the current grant.
- Changes to `dwell` during GRANT have no effect until the next arbitration.
- Arithmetic: `cnt` never underflows. The loaded value is ≥1 and decrements only while >1.

## Timing
- Reset values (asynchronous, while `rst_n`=0): state=IDLE, `sel`=0, `gnt`=0, `busy`=0, `ptr`=0, `cnt`=0, `valid`=0.
- Reset asserted mid-grant: outputs clear immediately and no beat is counted. After deassertion, arbitration restarts from `ptr`=0.
- Arbitration latency: `req` sampled high in IDLE at edge k gives `gnt`/`sel`/`busy` updated after edge k. `valid` can be high in cycle k+1.
- Release gap: the grant ends at the edge after the last beat or after the request drop. One IDLE cycle always separates consecutive grants, so the minimum grant period is dwell+1 cycles at full `ready`.
- `valid` depends combinationally on `req[sel]` and state; there is no combinational path from `ready` to any output.
- Simultaneous last beat and request drop cannot occur, because a beat requires `req[sel]`=1.

## Test plan
- Single requester: `req`=8'h10, `dwell`=3, `ready`=1. Required response:
  - `gnt`=8'h10 and `sel`=4 one cycle after the request.
  - Exactly 3 beats, then 1 IDLE cycle, then a re-grant to 4.
- Round robin: `req`=8'hFF, `dwell`=2, `ready`=1 from reset. Required response:
  - Grant order 0,1,2,…,7,0.
  - Each grant lasts 2 `valid` cycles and is followed by 1 idle cycle.
- Backpressure and wrap: grant index 7 with `dwell`=2 while `ready` is toggled 1,0,0,1. Required response:
  - Release after the second accepted beat.
  - `ptr` wraps to 0; with `req`=8'h81 the next grant goes to 0.
- Request drop: during a grant to 2 with `dwell`=5, deassert `req[2]` after 1 beat. Required response:
  - `valid`=0 that cycle and no further beats.
  - `gnt` returns to 0 at the next edge; `ptr`=3.
- `dwell`=0 and mid-grant change: with `dwell`=0, each grant lasts exactly 1 beat. Changing `dwell` from 2 to 6 during a grant still releases after 2 beats.
- Asynchronous reset mid-grant: pull `rst_n` low between edges. Required response:
  - `gnt`, `sel`, `valid` and `busy` go to 0 immediately.
  - After release of reset with `req`=8'h0C, the first grant is to 2.

Source files
------------

// File: rtl/mux8_rr_sched_if.sv
// mux8_rr_sched_if: request, dwell and handshake bundle between the requesters and the scheduler.
interface mux8_rr_sched_if #(parameter int DWELL_W = 4);
   logic [7:0]         req;
   logic [DWELL_W-1:0] dwell;
   logic               ready;
   logic [2:0]         sel;
   logic [7:0]         gnt;
   logic               valid;
   logic               busy;
   modport master(output req, dwell, ready, input sel, gnt, valid, busy);
   modport slave(input req, dwell, ready, output sel, gnt, valid, busy);
endinterface

// File: rtl/mux8_rr_sched.sv
// mux8_rr_sched: round-robin scheduler driving the select of an 8:1 mux.
// It holds each grant for a dwell count of accepted beats or until the owner drops its request.
module mux8_rr_sched #(parameter int DWELL_W = 4) (
   input logic            clk,
   input logic            rst_n,
   mux8_rr_sched_if.slave bus
);
   typedef enum logic {IDLE, GRANT} state_t;
   state_t             state_q, state_d;
   logic [2:0]         sel_q, sel_d, ptr_q, ptr_d, pick;
   logic [7:0]         gnt_q, gnt_d;
   logic [DWELL_W-1:0] cnt_q, cnt_d;
   logic               arb, beat, rel;
   always_comb begin
      // Scan from ptr+7 down to ptr, so the closest requester to ptr is the last one written.
      pick = ptr_q;
      for (int j = 7; j >= 0; j--)
         if (bus.req[ptr_q + 3'(j)]) pick = ptr_q + 3'(j);
      arb     = state_q == IDLE && |bus.req;
      beat    = state_q == GRANT && bus.req[sel_q] && bus.ready;
      rel     = state_q == GRANT && (!bus.req[sel_q] || (beat && cnt_q == DWELL_W'(1)));
      state_d = arb ? GRANT : rel ? IDLE : state_q;
      sel_d   = arb ? pick : sel_q;
      gnt_d   = arb ? 8'(1) << pick : rel ? 8'h00 : gnt_q;
      cnt_d   = arb ? (bus.dwell == '0 ? DWELL_W'(1) : DWELL_W'(bus.dwell)) :
                beat && cnt_q > DWELL_W'(1) ? cnt_q - DWELL_W'(1) : cnt_q;
      ptr_d   = rel ? sel_q + 3'd1 : ptr_q;
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state_q <= IDLE;
         sel_q   <= '0;
         gnt_q   <= '0;
         cnt_q   <= '0;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         gnt_q   <= gnt_d;
         cnt_q   <= cnt_d;
         ptr_q   <= ptr_d;
      end
   assign bus.sel   = sel_q;
   assign bus.gnt   = gnt_q;
   assign bus.busy  = state_q == GRANT;
   assign bus.valid = state_q == GRANT && bus.req[sel_q];
endmodule
